// File: rtl/node_pkg.sv
// Shared types and helpers for the skid-buffer pipeline node.
package node_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    // Width needed to count 0 .. 2*stages stored beats
    function automatic int occ_w(input int stages);
        return $clog2(2 * stages + 1);
    endfunction

endpackage

// File: rtl/node_skid_stage.sv
// One skid-buffer stage: main + skid register, every output taken from a flop.
// Both handshake directions are registered, so chaining stages never builds a comb path.
module node_skid_stage
    import node_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    skid_state_e      r_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_in_fire;
    logic             w_out_fire;

    assign o_ready    = (r_state != FULL);
    assign o_valid    = (r_state != EMPTY);
    assign o_data     = r_main;
    assign w_in_fire  = i_valid & o_ready;
    assign w_out_fire = o_valid & i_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        r_state <= BUSY;
                        r_main  <= i_data;
                    end
                end
                BUSY: begin
                    if (w_in_fire && !w_out_fire) begin
                        r_state <= FULL;
                        r_skid  <= i_data;
                    end else if (w_in_fire && w_out_fire) begin
                        r_main  <= i_data;
                    end else if (w_out_fire) begin
                        r_state <= EMPTY;
                    end
                end
                FULL: begin
                    if (w_out_fire) begin
                        r_state <= BUSY;
                        r_main  <= r_skid;
                    end
                end
                default: r_state <= EMPTY;
            endcase
            // Flush drops every stored beat and any beat arriving this cycle; data regs keep contents
            if (flush) begin
                r_state <= EMPTY;
            end
        end
    end

endmodule

// File: rtl/node_skid_pipe.sv
// Chain of STAGES skid stages between an upstream and a downstream valid/ready link.
// Optional occupancy / stall statistics when NODE_SKID_PIPE_STATS_EN is defined.
module node_skid_pipe
    import node_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             data_in,
    input  logic                         valid_up_in,
    output logic                         ready_up_out,
    output logic [WIDTH-1:0]             data_out,
    output logic                         valid_down_out,
    input  logic                         ready_down_in
`ifdef NODE_SKID_PIPE_STATS_EN
    ,
    output logic [occ_w(STAGES)-1:0]     occupancy,
    output logic [31:0]                  stall_cnt
`endif
);

    logic [STAGES:0]  w_valid;
    logic [STAGES:0]  w_ready;
    logic [WIDTH-1:0] w_data [STAGES+1];

    assign w_valid[0]      = valid_up_in;
    assign w_data[0]       = data_in;
    assign w_ready[STAGES] = ready_down_in;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            node_skid_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .flush   (flush),
                .i_data  (w_data[k]),
                .i_valid (w_valid[k]),
                .o_ready (w_ready[k]),
                .o_data  (w_data[k+1]),
                .o_valid (w_valid[k+1]),
                .i_ready (w_ready[k+1])
            );
        end
    endgenerate

    // Ready is held low while reset is asserted, before the state flops are known
    assign ready_up_out   = w_ready[0] & rst_n;
    assign valid_down_out = w_valid[STAGES];
    assign data_out       = w_data[STAGES];

`ifdef NODE_SKID_PIPE_STATS_EN
    localparam int OCC_W = occ_w(STAGES);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    logic [OCC_W-1:0] r_occ;
    logic [31:0]      r_stall;
    logic             w_up_fire;
    logic             w_down_fire;

    assign w_up_fire   = valid_up_in & ready_up_out;
    assign w_down_fire = valid_down_out & ready_down_in;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_occ   <= '0;
            r_stall <= '0;
        end else begin
            r_occ <= r_occ + OCC_W'(w_up_fire) - OCC_W'(w_down_fire);
            if (valid_down_out && !ready_down_in) begin
                r_stall <= sat_inc(r_stall);
            end
        end
    end

    assign occupancy = r_occ;
    assign stall_cnt = r_stall;
`endif

endmodule

// File: tb/tb_node_skid_pipe.sv
// Directed bench for node_skid_pipe (WIDTH=32, STAGES=2) plus a scoreboarded random segment.
module tb_node_skid_pipe;

    localparam int WIDTH  = 32;
    localparam int STAGES = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic [WIDTH-1:0] data_in;
    logic             valid_up_in;
    logic             ready_up_out;
    logic [WIDTH-1:0] data_out;
    logic             valid_down_out;
    logic             ready_down_in;
`ifdef NODE_SKID_PIPE_STATS_EN
    logic [2:0]       occupancy;
    logic [31:0]      stall_cnt;
`endif

    node_skid_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .data_in        (data_in),
        .valid_up_in    (valid_up_in),
        .ready_up_out   (ready_up_out),
        .data_out       (data_out),
        .valid_down_out (valid_down_out),
        .ready_down_in  (ready_down_in)
`ifdef NODE_SKID_PIPE_STATS_EN
        ,
        .occupancy      (occupancy),
        .stall_cnt      (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] q[$];
    logic [31:0] exp_v;
    int          n_acc;
    int          sent;
    int          rcvd;
    int          cyc;
    bit          up_f;
    bit          dn_f;
    int          duty;

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        valid_up_in   = 1'b1;
        data_in       = 32'hDEAD_BEEF;
        ready_down_in = 1'b0;

        // Reset held for three edges with valid asserted
        repeat (3) step();
        chk("rst_valid", valid_down_out, 1'b0);
        chk("rst_ready", ready_up_out, 1'b0);
        chk("rst_data", data_out, 32'h0);
        rst_n       = 1'b1;
        valid_up_in = 1'b0;
        #1;
        chk("post_rst_ready", ready_up_out, 1'b1);
        chk("post_rst_valid", valid_down_out, 1'b0);

        // Back-to-back stream, no backpressure
        ready_down_in = 1'b1;
        for (int i = 0; i < 18; i++) begin
            valid_up_in = (i < 16);
            data_in     = 32'(i + 1);
            if (i < 16) chk("stream_ready", ready_up_out, 1'b1);
            step();
            if (i >= 1 && i <= 16) begin
                chk("stream_valid", valid_down_out, 1'b1);
                chk("stream_data", data_out, 32'(i));
            end
            if (i == 17) chk("stream_drained", valid_down_out, 1'b0);
        end
        valid_up_in = 1'b0;

        // Full backpressure: capacity is 2*STAGES beats
        ready_down_in = 1'b0;
        n_acc = 0;
        for (int c = 0; c < 8; c++) begin
            valid_up_in = 1'b1;
            data_in     = 32'hA0 + 32'(n_acc);
            up_f        = ready_up_out;
            step();
            if (up_f) n_acc++;
        end
        chk("cap_count", 32'(n_acc), 32'd4);
        chk("cap_ready", ready_up_out, 1'b0);
        valid_up_in   = 1'b0;
        ready_down_in = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("cap_valid", valid_down_out, 1'b1);
            chk("cap_data", data_out, 32'hA0 + 32'(k));
            step();
        end
        chk("cap_drained", valid_down_out, 1'b0);

        // Flush with downstream FULL while a beat fires upstream in the same cycle
        ready_down_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            valid_up_in = 1'b1;
            data_in     = 32'hB0 + 32'(k);
            chk("fl_fill_ready", ready_up_out, 1'b1);
            step();
        end
        chk("fl_pre_valid", valid_down_out, 1'b1);
        chk("fl_pre_data", data_out, 32'hB0);
        data_in = 32'hB3;
        flush   = 1'b1;
        #1;
        chk("fl_upfire_ready", ready_up_out, 1'b1);
        step();
        flush       = 1'b0;
        valid_up_in = 1'b0;
        chk("fl_post_valid", valid_down_out, 1'b0);
        chk("fl_post_ready", ready_up_out, 1'b1);
        ready_down_in = 1'b1;
        valid_up_in   = 1'b1;
        data_in       = 32'hB4;
        step();
        valid_up_in = 1'b0;
        step();
        chk("fl_next_valid", valid_down_out, 1'b1);
        chk("fl_next_data", data_out, 32'hB4);
        step();
        chk("fl_next_drained", valid_down_out, 1'b0);

`ifdef NODE_SKID_PIPE_STATS_EN
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("st_clr_stall", stall_cnt, 32'd0);
        chk("st_clr_occ", 32'(occupancy), 32'd0);
        ready_down_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            valid_up_in = 1'b1;
            data_in     = 32'hC0 + 32'(k);
            step();
        end
        valid_up_in = 1'b0;
        chk("st_fill_occ", 32'(occupancy), 32'd4);
        chk("st_fill_stall", stall_cnt, 32'd2);
        repeat (3) step();
        chk("st_hold_stall", stall_cnt, 32'd5);
        chk("st_hold_occ", 32'(occupancy), 32'd4);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("st_flush_stall", stall_cnt, 32'd0);
        chk("st_flush_occ", 32'(occupancy), 32'd0);
`endif

        // Random valid/ready at varying duty with a FIFO scoreboard
        q.delete();
        sent        = 0;
        rcvd        = 0;
        cyc         = 0;
        valid_up_in = 1'b0;
        ready_down_in = 1'b0;
        while (rcvd < 2000 && cyc < 40000) begin
            up_f = valid_up_in & ready_up_out;
            dn_f = valid_down_out & ready_down_in;
            if (dn_f) begin
                if (q.size() == 0) begin
                    chk("rnd_spurious", data_out, 32'hFFFF_FFFF ^ data_out);
                end else begin
                    exp_v = q.pop_front();
                    chk("rnd_data", data_out, exp_v);
                end
                rcvd++;
            end
            if (up_f) begin
                q.push_back(data_in);
                sent++;
            end
            step();
            cyc++;
            case ((cyc / 500) % 3)
                0:       duty = 30;
                1:       duty = 50;
                default: duty = 90;
            endcase
            if (!valid_up_in || up_f) begin
                valid_up_in = (sent < 2000) && ($urandom_range(0, 99) < duty);
                data_in     = $urandom;
            end
            ready_down_in = ($urandom_range(0, 99) < (120 - duty));
        end
        chk("rnd_received", 32'(rcvd), 32'd2000);
        chk("rnd_leftover", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
